// File: rtl/y_event_pkg.sv
// Shared types for the Y event counter: report FSM states.
package y_event_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rpt_state_t;

endpackage

// File: rtl/sync_glitch_filter.sv
// Two-flop synchroniser plus stability filter for the raw detector output Y.
// Q follows the synchronised input only after STABLE_CYCLES consecutive differing samples.
module sync_glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic y,
  output logic q,
  output logic pulse
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0] LastCnt = StabW'(STABLE_CYCLES - 1);

  logic             y_meta_q;
  logic             y_s_q;
  logic [StabW-1:0] stab_q;
  logic [StabW-1:0] stab_d;
  logic             q_d;
  logic             pulse_d;

  always_comb begin
    stab_d  = '0;
    q_d     = q;
    pulse_d = 1'b0;
    if (y_s_q != q) begin
      // Final mismatch flips Q and re-arms the counter in the same cycle.
      if (stab_q == LastCnt) begin
        q_d     = y_s_q;
        pulse_d = y_s_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_meta_q <= 1'b0;
      y_s_q    <= 1'b0;
      stab_q   <= '0;
      q        <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      y_meta_q <= y;
      y_s_q    <= y_meta_q;
      stab_q   <= stab_d;
      q        <= q_d;
      pulse    <= pulse_d;
    end
  end

endmodule

// File: rtl/y_event_counter.sv
// Filters the detector output Y, counts qualified rising edges and reports the
// count to a host through a snapshot with a VALID/ACK handshake.
module y_event_counter
  import y_event_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y,
  input  logic             en,
  input  logic             clr,
  input  logic             ack,
  output logic             q,
  output logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snap,
  output logic             valid,
  output logic             pend,
  output logic             ovf
);

  rpt_state_t       state_q;
  rpt_state_t       state_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] snap_d;
  logic             pend_d;
  logic             ovf_d;
  logic             event_ok;
  logic             cnt_max;
  logic [CNT_W-1:0] count_inc;

  sync_glitch_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk  (clk),
    .reset(reset),
    .y    (y),
    .q    (q),
    .pulse(pulse)
  );

  assign event_ok  = pulse & en & ~clr;
  assign cnt_max   = &count;
  assign count_inc = cnt_max ? count : count + 1'b1;
  assign valid     = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    count_d = count;
    snap_d  = snap;
    pend_d  = pend;
    ovf_d   = ovf;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      snap_d  = '0;
      pend_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (event_ok) begin
        count_d = count_inc;
        if (cnt_max) ovf_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (event_ok) begin
            snap_d  = count_inc;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            pend_d = 1'b0;
            if (event_ok) begin
              snap_d = count_inc;
            end else if (pend) begin
              // Refresh with the events that arrived while the old snapshot waited.
              snap_d = count;
            end else begin
              state_d = IDLE;
            end
          end else if (event_ok) begin
            pend_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      snap    <= '0;
      pend    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      snap    <= snap_d;
      pend    <= pend_d;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_y_event_counter.sv
// Directed bench for y_event_counter: an 8-bit counter instance and a 3-bit one
// share the same stimulus so saturation can be reached quickly.
module tb_y_event_counter;

  logic       clk = 1'b0;
  logic       reset, y, en, clr, ack;
  logic       q, pulse, valid, pend, ovf;
  logic [7:0] count, snap;
  logic       q3, pulse3, valid3, pend3, ovf3;
  logic [2:0] count3, snap3;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int base;

  always #5 clk = ~clk;

  always @(negedge clk) if (pulse === 1'b1) pulse_cnt++;

  y_event_counter #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .y(y), .en(en), .clr(clr), .ack(ack),
    .q(q), .pulse(pulse), .count(count), .snap(snap),
    .valid(valid), .pend(pend), .ovf(ovf)
  );

  y_event_counter #(.STABLE_CYCLES(4), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .y(y), .en(en), .clr(clr), .ack(ack),
    .q(q3), .pulse(pulse3), .count(count3), .snap(snap3),
    .valid(valid3), .pend(pend3), .ovf(ovf3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Y high for hi cycles; for hi=6 the counting edge is the step where ack/clr are applied.
  task automatic ev(input int hi, input logic ack_ev, input logic clr_ev);
    y = 1'b1;
    repeat (hi) step();
    y   = 1'b0;
    ack = ack_ev;
    clr = clr_ev;
    step();
    ack = 1'b0;
    clr = 1'b0;
    repeat (5) step();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; y = 1'b1; en = 1'b1; clr = 1'b0; ack = 1'b0;

    // 1: reset with Y held high, then latency to first event
    step(); step();
    check_eq("t1_rst_q", q, 0);
    check_eq("t1_rst_pulse", pulse, 0);
    check_eq("t1_rst_count", count, 0);
    check_eq("t1_rst_snap", snap, 0);
    check_eq("t1_rst_valid", valid, 0);
    check_eq("t1_rst_pend", pend, 0);
    check_eq("t1_rst_ovf", ovf, 0);
    reset = 1'b0;
    repeat (5) step();
    check_eq("t1_q_cycle5", q, 0);
    step();
    check_eq("t1_q_cycle6", q, 1);
    check_eq("t1_pulse_cycle6", pulse, 1);
    step();
    check_eq("t1_pulse_cycle7", pulse, 0);
    check_eq("t1_count", count, 1);
    check_eq("t1_valid", valid, 1);
    check_eq("t1_snap", snap, 1);
    y = 1'b0;
    repeat (6) step();
    check_eq("t1_q_fall", q, 0);

    // 2: short glitch rejected, 4-sample pulse accepted
    do_clr();
    check_eq("t2_clr_valid", valid, 0);
    base = pulse_cnt;
    ev(3, 1'b0, 1'b0);
    check_eq("t2_glitch_pulses", pulse_cnt, base);
    check_eq("t2_glitch_count", count, 0);
    check_eq("t2_glitch_q", q, 0);
    ev(4, 1'b0, 1'b0);
    check_eq("t2_min_pulses", pulse_cnt, base + 1);
    check_eq("t2_min_count", count, 1);

    // 3: pending events and two-stage acknowledge
    do_clr();
    repeat (3) ev(6, 1'b0, 1'b0);
    check_eq("t3_snap", snap, 1);
    check_eq("t3_count", count, 3);
    check_eq("t3_pend", pend, 1);
    check_eq("t3_valid", valid, 1);
    do_ack();
    check_eq("t3_ack1_snap", snap, 3);
    check_eq("t3_ack1_pend", pend, 0);
    check_eq("t3_ack1_valid", valid, 1);
    do_ack();
    check_eq("t3_ack2_valid", valid, 0);
    do_ack();
    check_eq("t3_idle_ack_valid", valid, 0);
    check_eq("t3_idle_ack_snap", snap, 3);

    // 4: ACK coincident with an event while HOLD, COUNT=5
    ev(6, 1'b0, 1'b0);
    check_eq("t4_snap4", snap, 4);
    ev(6, 1'b0, 1'b0);
    check_eq("t4_count5", count, 5);
    check_eq("t4_pend_before", pend, 1);
    ev(6, 1'b1, 1'b0);
    check_eq("t4_snap", snap, 6);
    check_eq("t4_valid", valid, 1);
    check_eq("t4_pend", pend, 0);
    check_eq("t4_count", count, 6);

    // 5: saturation on the 3-bit instance, then CLR beating an event
    do_clr();
    for (int i = 0; i < 9; i++) begin
      ev(6, 1'b0, 1'b0);
      do_ack();
    end
    check_eq("t5_count3", count3, 7);
    check_eq("t5_snap3", snap3, 7);
    check_eq("t5_ovf3", ovf3, 1);
    check_eq("t5_valid3", valid3, 0);
    check_eq("t5_pend3", pend3, 0);
    check_eq("t5_count8", count, 9);
    check_eq("t5_ovf8", ovf, 0);
    ev(6, 1'b0, 1'b1);
    check_eq("t5_clr_count3", count3, 0);
    check_eq("t5_clr_ovf3", ovf3, 0);
    check_eq("t5_clr_valid3", valid3, 0);
    check_eq("t5_clr_count8", count, 0);

    // 6: EN=0 freezes counting; reset mid-filter while in HOLD
    en = 1'b0;
    base = pulse_cnt;
    repeat (2) ev(6, 1'b0, 1'b0);
    check_eq("t6_en0_pulses", pulse_cnt, base + 2);
    check_eq("t6_en0_count", count, 0);
    check_eq("t6_en0_valid", valid, 0);
    en = 1'b1;
    ev(6, 1'b0, 1'b0);
    check_eq("t6_hold_valid", valid, 1);
    y = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    check_eq("t6_rst_q", q, 0);
    check_eq("t6_rst_pulse", pulse, 0);
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_snap", snap, 0);
    check_eq("t6_rst_valid", valid, 0);
    check_eq("t6_rst_pend", pend, 0);
    check_eq("t6_rst_ovf", ovf, 0);
    reset = 1'b0;
    y = 1'b0;
    base = pulse_cnt;
    repeat (8) step();
    check_eq("t6_no_partial_pulse", pulse_cnt, base);
    check_eq("t6_post_q", q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
